// File: rtl/fpu_axi_mst.sv
// rtl/fpu_axi_mst.sv - AXI-lite master that runs one FPU operation per command
module fpu_axi_mst #(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter int          ADDR_WIDTH   = 32,
    parameter int          DATA_WIDTH   = 32,
    parameter int          STRB_WIDTH   = DATA_WIDTH / 8,
    parameter int          OPCODE_WIDTH = 5,
    parameter int          POLL_MAX     = 16
) (
    input  logic                    fpu_clk,
    input  logic                    fpu_rst,
    input  logic                    cmd_valid_i,
    output logic                    cmd_ready_o,
    input  logic [OPCODE_WIDTH-1:0] cmd_opcode_i,
    input  logic [2:0]              cmd_rmode_i,
    input  logic [DATA_WIDTH-1:0]   cmd_op1_i,
    input  logic [DATA_WIDTH-1:0]   cmd_op2_i,
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic [DATA_WIDTH-1:0]   rsp_result_o,
    output logic [4:0]              rsp_flag_o,
    output logic [1:0]              rsp_err_o,
    output logic                    awvalid_o,
    output logic [ADDR_WIDTH-1:0]   awaddr_o,
    input  logic                    awready_i,
    output logic                    wvalid_o,
    output logic [DATA_WIDTH-1:0]   wdata_o,
    output logic [STRB_WIDTH-1:0]   wstrb_o,
    input  logic                    wready_i,
    input  logic                    bvalid_i,
    input  logic [1:0]              bresp_i,
    output logic                    bready_o,
    output logic                    arvalid_o,
    output logic [ADDR_WIDTH-1:0]   araddr_o,
    input  logic                    arready_i,
    input  logic                    rvalid_i,
    input  logic [DATA_WIDTH-1:0]   rdata_i,
    input  logic [1:0]              rresp_i,
    output logic                    rready_o
);

    typedef enum logic [2:0] {
        IDLE, WR_ADDR_DATA, WR_RESP, RD_STAT_ADDR,
        RD_STAT_DATA, RD_RES_ADDR, RD_RES_DATA, RESP
    } state_t;

    localparam int                    PW   = $clog2(POLL_MAX + 1);
    localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [1:0]            OKAY = 2'b00;

    state_t                  state_q, state_d;
    logic [1:0]              wr_idx_q, wr_idx_d;
    logic [PW-1:0]           poll_cnt_q, poll_cnt_d;
    logic                    aw_done_q, aw_done_d;
    logic                    w_done_q, w_done_d;
    logic [OPCODE_WIDTH-1:0] opcode_q, opcode_d;
    logic [2:0]              rmode_q, rmode_d;
    logic [DATA_WIDTH-1:0]   op1_q, op1_d;
    logic [DATA_WIDTH-1:0]   op2_q, op2_d;
    logic [DATA_WIDTH-1:0]   result_q, result_d;
    logic [4:0]              flags_q, flags_d;
    logic [1:0]              err_q, err_d;
    logic [DATA_WIDTH-1:0]   ctrl_word;

    assign ctrl_word = DATA_WIDTH'({rmode_q, opcode_q});

    // State and datapath registers; reset wins over everything, mid-transaction included
    always_ff @(posedge fpu_clk) begin
        if (fpu_rst) begin
            state_q    <= IDLE;
            wr_idx_q   <= '0;
            poll_cnt_q <= '0;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
            opcode_q   <= '0;
            rmode_q    <= '0;
            op1_q      <= '0;
            op2_q      <= '0;
            result_q   <= '0;
            flags_q    <= '0;
            err_q      <= '0;
        end else begin
            state_q    <= state_d;
            wr_idx_q   <= wr_idx_d;
            poll_cnt_q <= poll_cnt_d;
            aw_done_q  <= aw_done_d;
            w_done_q   <= w_done_d;
            opcode_q   <= opcode_d;
            rmode_q    <= rmode_d;
            op1_q      <= op1_d;
            op2_q      <= op2_d;
            result_q   <= result_d;
            flags_q    <= flags_d;
            err_q      <= err_d;
        end
    end

    // Next-state sequencing: three register writes, status polling, result read, response
    always_comb begin
        state_d    = state_q;
        wr_idx_d   = wr_idx_q;
        poll_cnt_d = poll_cnt_q;
        aw_done_d  = aw_done_q;
        w_done_d   = w_done_q;
        opcode_d   = opcode_q;
        rmode_d    = rmode_q;
        op1_d      = op1_q;
        op2_d      = op2_q;
        result_d   = result_q;
        flags_d    = flags_q;
        err_d      = err_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid_i && cmd_ready_o) begin
                    opcode_d   = cmd_opcode_i;
                    rmode_d    = cmd_rmode_i;
                    op1_d      = cmd_op1_i;
                    op2_d      = cmd_op2_i;
                    wr_idx_d   = '0;
                    poll_cnt_d = '0;
                    aw_done_d  = 1'b0;
                    w_done_d   = 1'b0;
                    result_d   = '0;
                    flags_d    = '0;
                    err_d      = '0;
                    state_d    = WR_ADDR_DATA;
                end
            end
            WR_ADDR_DATA: begin
                // Each channel retires on its own handshake; leave once both have
                aw_done_d = aw_done_q | (awvalid_o & awready_i);
                w_done_d  = w_done_q | (wvalid_o & wready_i);
                if (aw_done_d && w_done_d) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = WR_RESP;
                end
            end
            WR_RESP: begin
                if (bvalid_i) begin
                    if (bresp_i != OKAY) begin
                        err_d   = 2'b01;
                        state_d = RESP;
                    end else if (wr_idx_q == 2'd2) begin
                        state_d = RD_STAT_ADDR;
                    end else begin
                        wr_idx_d = wr_idx_q + 2'd1;
                        state_d  = WR_ADDR_DATA;
                    end
                end
            end
            RD_STAT_ADDR: begin
                if (arready_i) state_d = RD_STAT_DATA;
            end
            RD_STAT_DATA: begin
                if (rvalid_i) begin
                    if (rresp_i != OKAY) begin
                        err_d   = 2'b10;
                        state_d = RESP;
                    end else if (rdata_i[8]) begin
                        flags_d = rdata_i[4:0];
                        state_d = RD_RES_ADDR;
                    end else if (poll_cnt_q == PW'(POLL_MAX - 1)) begin
                        err_d   = 2'b11;
                        state_d = RESP;
                    end else begin
                        poll_cnt_d = poll_cnt_q + 1'b1;
                        state_d    = RD_STAT_ADDR;
                    end
                end
            end
            RD_RES_ADDR: begin
                if (arready_i) state_d = RD_RES_DATA;
            end
            RD_RES_DATA: begin
                if (rvalid_i) begin
                    if (rresp_i != OKAY) begin
                        err_d    = 2'b10;
                        flags_d  = '0;
                        result_d = '0;
                    end else begin
                        result_d = rdata_i;
                    end
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Bus and response outputs decoded from state; addresses/data read zero when idle
    always_comb begin
        cmd_ready_o = (state_q == IDLE) && !fpu_rst;
        awvalid_o   = (state_q == WR_ADDR_DATA) && !aw_done_q;
        wvalid_o    = (state_q == WR_ADDR_DATA) && !w_done_q;
        bready_o    = (state_q == WR_RESP);
        arvalid_o   = (state_q == RD_STAT_ADDR) || (state_q == RD_RES_ADDR);
        rready_o    = (state_q == RD_STAT_DATA) || (state_q == RD_RES_DATA);
        awaddr_o    = '0;
        wdata_o     = '0;
        wstrb_o     = '0;
        araddr_o    = '0;
        if (awvalid_o) awaddr_o = BASE + ADDR_WIDTH'({wr_idx_q, 2'b00});
        if (wvalid_o) begin
            wstrb_o = '1;
            case (wr_idx_q)
                2'd0:    wdata_o = op1_q;
                2'd1:    wdata_o = op2_q;
                default: wdata_o = ctrl_word;
            endcase
        end
        if (state_q == RD_STAT_ADDR) araddr_o = BASE + ADDR_WIDTH'(8'h0C);
        if (state_q == RD_RES_ADDR)  araddr_o = BASE + ADDR_WIDTH'(8'h10);
        rsp_valid_o  = (state_q == RESP);
        rsp_result_o = result_q;
        rsp_flag_o   = flags_q;
        rsp_err_o    = err_q;
    end

endmodule

// File: tb/tb_fpu_axi_mst.sv
// tb/tb_fpu_axi_mst.sv - directed scoreboard bench for fpu_axi_mst with an AXI-lite slave model
module tb_fpu_axi_mst;

    localparam logic [31:0] BASE = 32'h4000_0000;

    logic        fpu_clk, fpu_rst;
    logic        cmd_valid_i, cmd_ready_o;
    logic [4:0]  cmd_opcode_i;
    logic [2:0]  cmd_rmode_i;
    logic [31:0] cmd_op1_i, cmd_op2_i;
    logic        rsp_valid_o, rsp_ready_i;
    logic [31:0] rsp_result_o;
    logic [4:0]  rsp_flag_o;
    logic [1:0]  rsp_err_o;
    logic        awvalid_o, awready_i, wvalid_o, wready_i, bvalid_i, bready_o;
    logic [31:0] awaddr_o, wdata_o;
    logic [3:0]  wstrb_o;
    logic [1:0]  bresp_i, rresp_i;
    logic        arvalid_o, arready_i, rvalid_i, rready_o;
    logic [31:0] araddr_o, rdata_i;

    fpu_axi_mst #(
        .BASE_ADDR(BASE), .ADDR_WIDTH(32), .DATA_WIDTH(32), .STRB_WIDTH(4),
        .OPCODE_WIDTH(5), .POLL_MAX(4)
    ) dut (
        .fpu_clk(fpu_clk), .fpu_rst(fpu_rst),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_opcode_i(cmd_opcode_i),
        .cmd_rmode_i(cmd_rmode_i), .cmd_op1_i(cmd_op1_i), .cmd_op2_i(cmd_op2_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_result_o(rsp_result_o),
        .rsp_flag_o(rsp_flag_o), .rsp_err_o(rsp_err_o),
        .awvalid_o(awvalid_o), .awaddr_o(awaddr_o), .awready_i(awready_i),
        .wvalid_o(wvalid_o), .wdata_o(wdata_o), .wstrb_o(wstrb_o), .wready_i(wready_i),
        .bvalid_i(bvalid_i), .bresp_i(bresp_i), .bready_o(bready_o),
        .arvalid_o(arvalid_o), .araddr_o(araddr_o), .arready_i(arready_i),
        .rvalid_i(rvalid_i), .rdata_i(rdata_i), .rresp_i(rresp_i), .rready_o(rready_o)
    );

    initial fpu_clk = 1'b0;
    always #5 fpu_clk = ~fpu_clk;

    int checks = 0;
    int errors = 0;

    logic [63:0] exp_wr[$];
    logic [38:0] exp_rsp[$];

    // slave configuration, set by the directed sequence
    int          aw_stall = 0;
    logic        b_err_en = 1'b0;
    logic [31:0] b_err_addr = '0;
    int          stat_ready_after = 1;
    logic [4:0]  stat_flags = '0;
    logic [31:0] res_data = '0;
    logic        r_err = 1'b0;

    // slave state and statistics
    int          aw_wait = 0, aw_hi = 0, w_hi = 0, last_aw_hi = 0, last_w_hi = 0;
    logic        aw_got = 1'b0, w_got = 1'b0, b_pend = 1'b0, r_pend = 1'b0;
    logic [31:0] got_addr = '0, got_data = '0, b_addr = '0, r_addr = '0;
    int          aw_hs_cnt = 0, b_hs_cnt = 0, ar_hs_cnt = 0, stat_reads = 0, res_reads = 0;
    int          poll_in_cmd = 0, prot_err = 0, cyc = 0, rsp_cnt = 0, acc_cyc = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // AXI-lite slave model and response monitor; decides inputs for the coming rising edge
    always @(negedge fpu_clk) begin
        cyc++;
        if (fpu_rst) begin
            awready_i = 1'b0; wready_i = 1'b0; bvalid_i = 1'b0; bresp_i = 2'b00;
            arready_i = 1'b0; rvalid_i = 1'b0; rdata_i = '0; rresp_i = 2'b00;
            aw_got = 1'b0; w_got = 1'b0; b_pend = 1'b0; r_pend = 1'b0;
            aw_wait = 0; aw_hi = 0; w_hi = 0;
        end else begin
            if (awvalid_o && arvalid_o) prot_err++;
            if ((awvalid_o || wvalid_o || b_pend) && (arvalid_o || r_pend)) prot_err++;
            bvalid_i = b_pend;
            bresp_i  = (b_pend && b_err_en && b_addr == b_err_addr) ? 2'b10 : 2'b00;
            if (b_pend && bready_o) begin
                b_hs_cnt++;
                b_pend = 1'b0;
            end
            rvalid_i = r_pend;
            rdata_i  = '0;
            rresp_i  = 2'b00;
            if (r_pend) begin
                rresp_i = r_err ? 2'b10 : 2'b00;
                if (r_addr == BASE + 32'h0C)
                    rdata_i = {23'd0, (poll_in_cmd + 1 >= stat_ready_after), 3'd0, stat_flags};
                else if (r_addr == BASE + 32'h10)
                    rdata_i = res_data;
                if (rready_o) begin
                    if (r_addr == BASE + 32'h0C) begin
                        stat_reads++;
                        poll_in_cmd++;
                    end else begin
                        res_reads++;
                    end
                    r_pend = 1'b0;
                end
            end
            awready_i = awvalid_o && (aw_wait >= aw_stall);
            if (awvalid_o) aw_hi++;
            if (awvalid_o && awready_i) begin
                aw_hs_cnt++;
                aw_got   = 1'b1;
                got_addr = awaddr_o;
            end else if (awvalid_o) begin
                aw_wait++;
            end
            wready_i = 1'b1;
            if (wvalid_o) begin
                w_hi++;
                w_got    = 1'b1;
                got_data = wdata_o;
                if (wstrb_o != 4'hF) prot_err++;
            end
            if (aw_got && w_got) begin
                if (exp_wr.size() == 0) chk("wr_unexpected", {got_addr, got_data}, 64'd0);
                else chk("wr_beat", {got_addr, got_data}, exp_wr.pop_front());
                b_pend = 1'b1; b_addr = got_addr;
                last_aw_hi = aw_hi; last_w_hi = w_hi;
                aw_hi = 0; w_hi = 0; aw_wait = 0; aw_got = 1'b0; w_got = 1'b0;
            end
            arready_i = arvalid_o;
            if (arvalid_o) begin
                ar_hs_cnt++;
                r_pend = 1'b1;
                r_addr = araddr_o;
            end
            if (rsp_valid_o && rsp_ready_i) begin
                if (exp_rsp.size() == 0) chk("rsp_unexpected", {rsp_result_o, rsp_flag_o, rsp_err_o}, 64'd0);
                else chk("rsp", {rsp_result_o, rsp_flag_o, rsp_err_o}, exp_rsp.pop_front());
                rsp_cnt++;
            end
        end
    end

    task automatic step();
        @(posedge fpu_clk);
        #1;
    endtask

    task automatic do_cmd(input logic [4:0] op, input logic [2:0] rm, input logic [31:0] a,
                          input logic [31:0] b, input int nwr, input logic [38:0] er, input bit push);
        logic [31:0] d[3];
        int n;
        d[0] = a; d[1] = b; d[2] = {24'd0, rm, op};
        for (int i = 0; i < nwr; i++) exp_wr.push_back({BASE + 32'(4 * i), d[i]});
        if (push) exp_rsp.push_back(er);
        cmd_opcode_i = op; cmd_rmode_i = rm; cmd_op1_i = a; cmd_op2_i = b;
        cmd_valid_i = 1'b1;
        n = 0;
        while (!cmd_ready_o && n < 300) begin
            step();
            n++;
        end
        chk("cmd_accept_in_time", 64'(n < 300), 64'd1);
        step();
        cmd_valid_i = 1'b0;
        acc_cyc = cyc;
        poll_in_cmd = 0;
    endtask

    task automatic wait_rsp(input int target);
        int n;
        n = 0;
        while (rsp_cnt < target && n < 500) begin
            step();
            n++;
        end
        chk("rsp_in_time", 64'(rsp_cnt >= target), 64'd1);
    endtask

    initial begin
        int acc_a, s0, r0, a0, b0, ar0, n;
        fpu_rst = 1'b1; rsp_ready_i = 1'b1; cmd_valid_i = 1'b0;
        cmd_opcode_i = '0; cmd_rmode_i = '0; cmd_op1_i = '0; cmd_op2_i = '0;
        awready_i = 1'b0; wready_i = 1'b0; bvalid_i = 1'b0; bresp_i = 2'b00;
        arready_i = 1'b0; rvalid_i = 1'b0; rdata_i = '0; rresp_i = 2'b00;
        repeat (3) step();
        chk("rst_cmd_ready", 64'(cmd_ready_o), 64'd0);
        chk("rst_valids", 64'({awvalid_o, wvalid_o, bready_o, arvalid_o, rready_o, rsp_valid_o}), 64'd0);
        chk("rst_addr", {awaddr_o, araddr_o}, 64'd0);
        chk("rst_rsp", 64'({rsp_result_o, rsp_flag_o, rsp_err_o}), 64'd0);
        fpu_rst = 1'b0;
        #1;
        chk("ready_after_rst", 64'(cmd_ready_o), 64'd1);

        // ADD 1.0 + 2.0, then a second command back-to-back to measure acceptance spacing
        stat_ready_after = 1; stat_flags = 5'd0; res_data = 32'h4040_0000;
        s0 = stat_reads; r0 = res_reads;
        do_cmd(5'b00011, 3'b000, 32'h3F80_0000, 32'h4000_0000, 3, {32'h4040_0000, 5'd0, 2'b00}, 1);
        acc_a = acc_cyc;
        do_cmd(5'b00100, 3'b001, 32'hC000_0000, 32'h3F00_0000, 3, {32'h4040_0000, 5'd0, 2'b00}, 1);
        chk("accept_gap_ge_11", 64'(acc_cyc - acc_a >= 11), 64'd1);
        wait_rsp(2);
        chk("add_stat_reads", 64'(stat_reads - s0), 64'd2);
        chk("add_res_reads", 64'(res_reads - r0), 64'd2);

        // AW backpressure of 3 cycles, status ready on third poll
        aw_stall = 3; stat_ready_after = 3; stat_flags = 5'b00010; res_data = 32'h4150_0000;
        s0 = stat_reads; a0 = aw_hs_cnt; b0 = b_hs_cnt;
        do_cmd(5'b00101, 3'b011, 32'h4040_0000, 32'h3F80_0000, 3, {32'h4150_0000, 5'b00010, 2'b00}, 1);
        wait_rsp(3);
        chk("aw_hold_cycles", 64'(last_aw_hi), 64'd4);
        chk("w_hold_cycles", 64'(last_w_hi), 64'd1);
        chk("bp_aw_count", 64'(aw_hs_cnt - a0), 64'd3);
        chk("bp_b_per_write", 64'(b_hs_cnt - b0), 64'd3);
        chk("bp_stat_reads", 64'(stat_reads - s0), 64'd3);
        aw_stall = 0;

        // SLVERR on the operand2 write aborts before control write and any read
        b_err_en = 1'b1; b_err_addr = BASE + 32'h04; stat_ready_after = 1; res_data = 32'hDEAD_BEEF;
        a0 = aw_hs_cnt; ar0 = ar_hs_cnt;
        do_cmd(5'b00011, 3'b010, 32'h0000_0001, 32'h0000_0002, 2, {32'h0, 5'd0, 2'b01}, 1);
        wait_rsp(4);
        chk("berr_aw_count", 64'(aw_hs_cnt - a0), 64'd2);
        chk("berr_no_ar", 64'(ar_hs_cnt - ar0), 64'd0);
        b_err_en = 1'b0;

        // status never ready: exactly POLL_MAX reads then timeout, flags not latched
        stat_ready_after = 100; stat_flags = 5'b11111;
        s0 = stat_reads; r0 = res_reads;
        do_cmd(5'b00110, 3'b000, 32'h1111_1111, 32'h2222_2222, 3, {32'h0, 5'd0, 2'b11}, 1);
        wait_rsp(5);
        chk("poll_timeout_reads", 64'(stat_reads - s0), 64'd4);
        chk("poll_timeout_no_res", 64'(res_reads - r0), 64'd0);

        // ready on the last permitted poll still succeeds
        stat_ready_after = 4; stat_flags = 5'b01000; res_data = 32'h7F80_0000;
        s0 = stat_reads; r0 = res_reads;
        do_cmd(5'b00111, 3'b100, 32'h7F00_0000, 32'h7F00_0000, 3, {32'h7F80_0000, 5'b01000, 2'b00}, 1);
        wait_rsp(6);
        chk("poll_last_reads", 64'(stat_reads - s0), 64'd4);
        chk("poll_last_res", 64'(res_reads - r0), 64'd1);

        // read error on the status beat
        r_err = 1'b1; stat_ready_after = 1; stat_flags = 5'b00100;
        r0 = res_reads;
        do_cmd(5'b00011, 3'b000, 32'h3333_3333, 32'h4444_4444, 3, {32'h0, 5'd0, 2'b10}, 1);
        wait_rsp(7);
        chk("rerr_no_res", 64'(res_reads - r0), 64'd0);
        r_err = 1'b0;

        // reset pulse while waiting on a status beat
        stat_ready_after = 100;
        do_cmd(5'b01000, 3'b000, 32'h5555_5555, 32'h6666_6666, 3, 39'd0, 0);
        n = 0;
        while (!rready_o && n < 100) begin
            step();
            n++;
        end
        chk("reached_rd_stat_data", 64'(rready_o), 64'd1);
        fpu_rst = 1'b1;
        step();
        chk("mid_rst_cmd_ready", 64'(cmd_ready_o), 64'd0);
        chk("mid_rst_valids", 64'({awvalid_o, wvalid_o, bready_o, arvalid_o, rready_o, rsp_valid_o}), 64'd0);
        chk("mid_rst_addr", {awaddr_o, araddr_o}, 64'd0);
        chk("mid_rst_data", {wdata_o, 28'd0, wstrb_o}, 64'd0);
        chk("mid_rst_rsp", 64'({rsp_result_o, rsp_flag_o, rsp_err_o}), 64'd0);
        fpu_rst = 1'b0;
        #1;
        chk("mid_rst_ready_after", 64'(cmd_ready_o), 64'd1);

        // response held under rsp_ready_i low
        rsp_ready_i = 1'b0; stat_ready_after = 1; stat_flags = 5'b00001; res_data = 32'h1234_5678;
        do_cmd(5'b00011, 3'b001, 32'h3F80_0000, 32'h3F80_0000, 3, {32'h1234_5678, 5'b00001, 2'b00}, 1);
        n = 0;
        while (!rsp_valid_o && n < 100) begin
            step();
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            chk("hold_valid", 64'(rsp_valid_o), 64'd1);
            chk("hold_fields", 64'({rsp_result_o, rsp_flag_o, rsp_err_o}), {25'd0, 32'h1234_5678, 5'b00001, 2'b00});
            step();
        end
        rsp_ready_i = 1'b1;
        wait_rsp(8);

        step();
        chk("wr_queue_empty", 64'(exp_wr.size()), 64'd0);
        chk("rsp_queue_empty", 64'(exp_rsp.size()), 64'd0);
        chk("protocol_violations", 64'(prot_err), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fpu_axi_mst.md
FPU_AXI_MST -- requirements
Module: fpu_axi_mst

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_0000, FPU register-map base address.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, AXI address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 32, AXI data and operand width.
REQ-004 SHALL have parameter STRB_WIDTH, default DATA_WIDTH/8, write-strobe width.
REQ-005 SHALL have parameter OPCODE_WIDTH, default 5, FPU opcode width.
REQ-006 SHALL have parameter POLL_MAX, default 16, maximum status reads per command.
REQ-007 SHALL have ports: fpu_clk in 1, the only clock; fpu_rst in 1, synchronous active-high reset.
REQ-008 SHALL have command ports: cmd_valid_i in 1; cmd_ready_o out 1; cmd_opcode_i in OPCODE_WIDTH; cmd_rmode_i in 3, round mode; cmd_op1_i in DATA_WIDTH; cmd_op2_i in DATA_WIDTH.
REQ-009 SHALL have response ports: rsp_valid_o out 1; rsp_ready_i in 1; rsp_result_o out DATA_WIDTH; rsp_flag_o out 5, {nan,inf,ovf,uf,zf}; rsp_err_o out 2.
REQ-010 SHALL have AXI-lite master write ports: awvalid_o out 1; awaddr_o out ADDR_WIDTH; awready_i in 1; wvalid_o out 1; wdata_o out DATA_WIDTH; wstrb_o out STRB_WIDTH; wready_i in 1; bvalid_i in 1; bresp_i in 2; bready_o out 1.
REQ-011 SHALL have AXI-lite master read ports: arvalid_o out 1; araddr_o out ADDR_WIDTH; arready_i in 1; rvalid_i in 1; rdata_i in DATA_WIDTH; rresp_i in 2; rready_o out 1.

Function
REQ-012 SHALL use the map: BASE+0x00 operand1, +0x04 operand2, +0x08 control {rmode[7:5],opcode[4:0]}, +0x0C status (bit8 result ready, bits4:0 flags), +0x10 result.
REQ-013 SHALL implement states IDLE, WR_ADDR_DATA, WR_RESP, RD_STAT_ADDR, RD_STAT_DATA, RD_RES_ADDR, RD_RES_DATA, RESP.
REQ-014 SHALL assert cmd_ready_o only in IDLE; on cmd_valid_i&cmd_ready_o capture all cmd fields, clear write index and poll counter, go to WR_ADDR_DATA.
REQ-015 SHALL in WR_ADDR_DATA assert awvalid_o and wvalid_o in the same cycle with index-selected address/data, wstrb_o all ones.
REQ-016 SHALL drop each of awvalid_o/wvalid_o independently on its own handshake, hold the other until its handshake, and move to WR_RESP once both complete (same or different cycles).
REQ-017 SHALL in WR_RESP assert bready_o; on bvalid_i with bresp_i==OKAY advance index 0->1->2 returning to WR_ADDR_DATA, after index 2 go to RD_STAT_ADDR; with bresp_i!=OKAY set err=01 and go to RESP.
REQ-018 SHALL issue araddr_o=BASE+0x0C in RD_STAT_ADDR with arvalid_o held until arready_i, then assert rready_o in RD_STAT_DATA.
REQ-019 SHALL on status beat: rresp_i!=OKAY -> err=10, RESP; rdata_i[8]=1 -> latch flags rdata_i[4:0], RD_RES_ADDR; else increment poll counter, RD_STAT_ADDR, or err=11, RESP when count reaches POLL_MAX.
REQ-020 SHALL read BASE+0x10 in RD_RES_ADDR/RD_RES_DATA; rresp_i!=OKAY -> err=10; latch rdata_i into result; go to RESP.
REQ-021 SHALL hold rsp_valid_o and all rsp fields stable in RESP until rsp_ready_i, then return to IDLE; on error result and flags SHALL be zero.
REQ-022 SHALL never have more than one outstanding AXI transaction and never assert AR and AW channels together.
REQ-023 SHALL, error-free with zero-wait slave, accept the next command no earlier than 3x2 write cycles + 2 cycles per status read + 2 result cycles + 1 response cycle after acceptance.

Reset
REQ-024 SHALL on fpu_rst high at any clock edge, including mid-transaction, go to IDLE and drive all valid/ready outputs 0, cmd_ready_o 0 during reset, addresses/data/results/flags/err 0.
REQ-025 SHALL assert cmd_ready_o the first cycle after fpu_rst deasserts.

Verification
REQ-026 ADD: opcode 00011, rmode 000, op1 32'h3F80_0000, op2 32'h4000_0000, status ready first poll, result 32'h4040_0000 -> writes 0x00/0x04/0x08 with data op1/op2/32'h0000_0003, rsp_result_o 32'h4040_0000, err 00.
REQ-027 Backpressure: awready_i low 3 cycles, wready_i high -> wvalid_o drops after 1 cycle, awvalid_o held 4 cycles, exactly one B handshake per write.
REQ-028 bresp_i=2'b10 on operand2 write -> no control write, no AR issued, rsp_err_o 01, result 0.
REQ-029 POLL_MAX=4, status bit8 never set -> exactly 4 status reads, rsp_err_o 11, no result read.
REQ-030 fpu_rst pulsed during RD_STAT_DATA, then rsp_ready_i held low 5 cycles on next command -> all outputs 0 after reset, rsp_valid_o and fields stable 5 cycles.
